mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arb_rr.sv | 26 ++
 rtl/mem_arbiter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types for the two-master memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, CMD, RBURST, WBURST)
//   owner_t     : which master currently owns the memory bus
//   REQ_I/REQ_D : bit positions of the I-side / D-side request in req vectors
//   other_side(): the opposite owner, used by the round-robin tie break
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RBURST = 2'd2,
        WBURST = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    function automatic owner_t other_side(input owner_t o);
        return (o == OWN_I) ? OWN_D : OWN_I;
    endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr -- purely combinational 2-input round-robin picker.
// Ports:
//   req[1:0] : request vector, bit REQ_I = I-side, bit REQ_D = D-side
//   last     : side that was served most recently
//   winner   : side to grant; on a tie the side not served last wins.
//              Meaningless when req is 0 (caller only looks when |req).
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last,
    output owner_t     winner
);

    always_comb begin
        winner = OWN_I;
        if (req[REQ_I] && req[REQ_D]) begin
            winner = other_side(last);
        end else if (req[REQ_D]) begin
            winner = OWN_D;
        end else begin
            winner = OWN_I;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter -- arbitrates an I-side (read-only refill) master and a D-side
// (read/write) master onto one burst memory port.
// Ports:
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   i_req/i_addr              : I-side burst request and start address
//   i_gnt/i_rvalid/i_rdata    : I-side grant and read beats
//   i_done                    : one-cycle pulse on the last I-side beat
//   d_req/d_we/d_addr/d_wdata : D-side request, direction, address, write data
//   d_wready                  : D-side write beat accepted by memory
//   d_gnt/d_rvalid/d_rdata    : D-side grant and read beats
//   d_done                    : one-cycle pulse on the last D-side beat
//   m_cmd_valid/m_cmd_ready   : memory command handshake
//   m_we/m_addr               : command direction and burst start address
//   m_wvalid/m_wready/m_wdata : memory write beat channel
//   m_rvalid/m_rdata          : memory read beat channel
// Each burst is BURST_LEN beats; the memory walks the address itself, so
// m_addr only ever carries the start address.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,

    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_done,

    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_wready,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_done,

    output logic                  m_cmd_valid,
    input  logic                  m_cmd_ready,
    output logic                  m_we,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata
);

    localparam int              CNT_W     = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t            state_reg;
    owner_t                owner_reg;
    owner_t                last_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  i_gnt_reg;
    logic                  d_gnt_reg;
    logic                  m_cmd_valid_reg;
    logic                  m_we_reg;
    logic [ADDR_WIDTH-1:0] m_addr_reg;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [1:0] req_vec;
    owner_t     winner;

    assign req_vec[REQ_I] = i_req;
    assign req_vec[REQ_D] = d_req;

    mem_arb_rr u_rr (
        .req    (req_vec),
        .last   (last_reg),
        .winner (winner)
    );

    // ------------------------------------------------------------------
    // Beat detection
    // ------------------------------------------------------------------
    logic rd_phase;
    logic wr_phase;
    logic rd_beat;
    logic wr_beat;
    logic beat;
    logic last_beat;

    assign rd_phase  = (state_reg == RBURST);
    // Only the D-side ever latches we=1, so WBURST implies D ownership; the
    // owner term just keeps the write channel shut if that ever breaks.
    assign wr_phase  = (state_reg == WBURST) && (owner_reg == OWN_D);
    assign rd_beat   = rd_phase && m_rvalid;
    assign wr_beat   = wr_phase && d_req && m_wready;
    assign beat      = rd_beat || wr_beat;
    assign last_beat = beat && (cnt_reg == LAST_BEAT);

    // ------------------------------------------------------------------
    // Per-side read/done steering. Read data passes straight through in
    // the beat cycle; the non-owner always sees zeros.
    // ------------------------------------------------------------------
    logic                  side_rvalid [2];
    logic [DATA_WIDTH-1:0] side_rdata  [2];
    logic                  side_done   [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_side
        logic side_sel;
        assign side_sel        = ((owner_reg == OWN_D) == (gi == REQ_D));
        assign side_rvalid[gi] = rd_beat && side_sel;
        assign side_rdata[gi]  = side_rvalid[gi] ? m_rdata : '0;
        assign side_done[gi]   = last_beat && side_sel;
    end

    assign i_rvalid = side_rvalid[REQ_I];
    assign i_rdata  = side_rdata[REQ_I];
    assign i_done   = side_done[REQ_I];
    assign d_rvalid = side_rvalid[REQ_D];
    assign d_rdata  = side_rdata[REQ_D];
    assign d_done   = side_done[REQ_D];

    // Write channel is a straight connection to the D-side during WBURST.
    assign m_wvalid = wr_phase && d_req;
    assign m_wdata  = wr_phase ? d_wdata : '0;
    assign d_wready = wr_phase ? m_wready : 1'b0;

    assign i_gnt       = i_gnt_reg;
    assign d_gnt       = d_gnt_reg;
    assign m_cmd_valid = m_cmd_valid_reg;
    assign m_we        = m_we_reg;
    assign m_addr      = m_addr_reg;

    // ------------------------------------------------------------------
    // FSM with registered grant / command outputs
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg       <= IDLE;
            owner_reg       <= OWN_I;
            last_reg        <= OWN_I;
            cnt_reg         <= '0;
            i_gnt_reg       <= 1'b0;
            d_gnt_reg       <= 1'b0;
            m_cmd_valid_reg <= 1'b0;
            m_we_reg        <= 1'b0;
            m_addr_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_vec) begin
                        owner_reg       <= winner;
                        m_addr_reg      <= (winner == OWN_D) ? d_addr : i_addr;
                        m_we_reg        <= (winner == OWN_D) && d_we;
                        i_gnt_reg       <= (winner == OWN_I);
                        d_gnt_reg       <= (winner == OWN_D);
                        m_cmd_valid_reg <= 1'b1;
                        state_reg       <= CMD;
                    end
                end

                CMD: begin
                    // Address/we are held in registers, so they stay stable
                    // for as long as the memory stalls the command.
                    if (m_cmd_ready) begin
                        m_cmd_valid_reg <= 1'b0;
                        cnt_reg         <= '0;
                        state_reg       <= m_we_reg ? WBURST : RBURST;
                    end
                end

                RBURST, WBURST: begin
                    if (beat) begin
                        // Natural wrap brings the counter back to 0 at burst end.
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == LAST_BEAT) begin
                            i_gnt_reg <= 1'b0;
                            d_gnt_reg <= 1'b0;
                            last_reg  <= owner_reg;
                            state_reg <= IDLE;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
